// File: rtl/vol_pkg.sv
// Shared types and helpers for the volume step controller.
package vol_pkg;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, FADE} state_t;

  localparam logic [3:0] LEVEL_MAX = 4'd8;

  // Thermometer mask with the low `lvl` bits set; lvl=8 gives 8'hFF.
  function automatic logic [7:0] therm_mask(input logic [3:0] lvl);
    logic [8:0] m;
    m = (9'd1 << lvl) - 9'd1;
    return m[7:0];
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync_2ff (
  input  logic Clk,
  input  logic Reset,
  input  logic d,
  output logic q
);

  logic meta_p0;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      meta_p0 <= 1'b0;
      q       <= 1'b0;
    end else begin
      meta_p0 <= d;
      q       <= meta_p0;
    end
  end

endmodule

// File: rtl/vol_step_ctrl.sv
// Volume step controller: debounced up/down buttons with auto-repeat and an
// automatic fade sequencer, owning the 0..8 level and its thermometer mask.
module vol_step_ctrl
  import vol_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [23:0] REPEAT_CYCLES   = 24'd5000000,
  parameter logic [23:0] FADE_PERIOD     = 24'd2500000,
  parameter logic [3:0]  INIT_LEVEL      = 4'd0
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btn_up,
  input  logic       btn_dn,
  input  logic       fade_start,
  input  logic       fade_dir,
  output logic [3:0] level,
  output logic [7:0] therm,
  output logic       step_up,
  output logic       step_dn,
  output logic       fade_active,
  output logic       fade_done
);

  logic        s_up, s_dn;
  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [23:0] rcnt, rcnt_nxt;
  logic [23:0] timer, timer_nxt;
  logic        dir, dir_nxt;
  logic        fdir, fdir_nxt;
  logic        req_up, req_dn;
  logic        done_nxt;
  logic        up_ok, dn_ok;
  logic [3:0]  level_nxt;
  logic        press_vld, latched_held, fade_at_target, fade_end;

  sync_2ff u_sync_up (.Clk(Clk), .Reset(Reset), .d(btn_up), .q(s_up));
  sync_2ff u_sync_dn (.Clk(Clk), .Reset(Reset), .d(btn_dn), .q(s_dn));

  assign press_vld      = s_up ^ s_dn;
  assign latched_held   = press_vld && (s_up == dir);
  assign fade_at_target = fade_dir ? (level == LEVEL_MAX) : (level == 4'd0);
  // A fade step that lands on (or is already at) the end level finishes the fade.
  assign fade_end       = fdir ? (level >= LEVEL_MAX - 4'd1) : (level <= 4'd1);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rcnt_nxt  = rcnt;
    timer_nxt = timer;
    dir_nxt   = dir;
    fdir_nxt  = fdir;
    req_up    = 1'b0;
    req_dn    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        if (press_vld) begin
          state_nxt = DEBOUNCE;
          cnt_nxt   = 16'd0;
          dir_nxt   = s_up;
        end else if (fade_start && !fade_at_target) begin
          state_nxt = FADE;
          timer_nxt = 24'd0;
          fdir_nxt  = fade_dir;
        end
      end
      DEBOUNCE: begin
        if (!latched_held) begin
          state_nxt = IDLE;
        end else if (cnt == DEBOUNCE_CYCLES - 16'd1) begin
          req_up    = dir;
          req_dn    = !dir;
          state_nxt = HOLD;
          rcnt_nxt  = 24'd0;
        end else begin
          cnt_nxt = cnt + 16'd1;
        end
      end
      HOLD: begin
        if (!s_up && !s_dn) begin
          state_nxt = IDLE;
        end else if ((REPEAT_CYCLES != 24'd0) && latched_held) begin
          if (rcnt == REPEAT_CYCLES - 24'd1) begin
            req_up   = dir;
            req_dn   = !dir;
            rcnt_nxt = 24'd0;
          end else begin
            rcnt_nxt = rcnt + 24'd1;
          end
        end
      end
      FADE: begin
        if (s_up || s_dn) begin
          state_nxt = IDLE;
        end else if (timer == FADE_PERIOD - 24'd1) begin
          timer_nxt = 24'd0;
          req_up    = fdir;
          req_dn    = !fdir;
          if (fade_end) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          timer_nxt = timer + 24'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    up_ok     = req_up && (level < LEVEL_MAX);
    dn_ok     = req_dn && (level != 4'd0);
    level_nxt = level;
    if (up_ok)      level_nxt = level + 4'd1;
    else if (dn_ok) level_nxt = level - 4'd1;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      cnt       <= 16'd0;
      rcnt      <= 24'd0;
      timer     <= 24'd0;
      dir       <= 1'b0;
      fdir      <= 1'b0;
      level     <= INIT_LEVEL;
      therm     <= therm_mask(INIT_LEVEL);
      step_up   <= 1'b0;
      step_dn   <= 1'b0;
      fade_done <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rcnt      <= rcnt_nxt;
      timer     <= timer_nxt;
      dir       <= dir_nxt;
      fdir      <= fdir_nxt;
      level     <= level_nxt;
      therm     <= therm_mask(level_nxt);
      step_up   <= up_ok;
      step_dn   <= dn_ok;
      fade_done <= done_nxt;
    end
  end

  assign fade_active = (state == FADE);

endmodule

// File: tb/tb_vol_step_ctrl.sv
// Directed bench for vol_step_ctrl with short debounce/repeat/fade timings.
module tb_vol_step_ctrl;

  logic       Clk = 1'b0;
  logic       Reset, btn_up, btn_dn, fade_start, fade_dir;
  logic [3:0] level;
  logic [7:0] therm;
  logic       step_up, step_dn, fade_active, fade_done;

  logic       reset2, btn_up2;
  logic [3:0] level2;
  logic [7:0] therm2;
  logic       step_up2, step_dn2, fade_active2, fade_done2;

  int n_chk = 0, n_fail = 0;
  int n_up = 0, n_dn = 0, n_done = 0;

  typedef struct {
    logic up;
    logic dn;
    int   cyc;
    int   lvl;
    int   nup;
    int   ndn;
  } vec_t;

  vec_t tbl[10];

  always #5 Clk = ~Clk;

  vol_step_ctrl #(
    .DEBOUNCE_CYCLES(16'd4), .REPEAT_CYCLES(24'd8),
    .FADE_PERIOD(24'd3), .INIT_LEVEL(4'd0)
  ) dut (
    .Clk(Clk), .Reset(Reset), .btn_up(btn_up), .btn_dn(btn_dn),
    .fade_start(fade_start), .fade_dir(fade_dir), .level(level), .therm(therm),
    .step_up(step_up), .step_dn(step_dn), .fade_active(fade_active),
    .fade_done(fade_done)
  );

  vol_step_ctrl #(
    .DEBOUNCE_CYCLES(16'd4), .REPEAT_CYCLES(24'd8),
    .FADE_PERIOD(24'd3), .INIT_LEVEL(4'd2)
  ) dut2 (
    .Clk(Clk), .Reset(reset2), .btn_up(btn_up2), .btn_dn(1'b0),
    .fade_start(1'b0), .fade_dir(1'b0), .level(level2), .therm(therm2),
    .step_up(step_up2), .step_dn(step_dn2), .fade_active(fade_active2),
    .fade_done(fade_done2)
  );

  always @(negedge Clk) begin
    n_up   += int'(step_up);
    n_dn   += int'(step_dn);
    n_done += int'(fade_done);
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    int up0, dn0, done0;

    tbl[0] = '{1'b1, 1'b0,  4, 1, 0, 0};
    tbl[1] = '{1'b1, 1'b0,  3, 1, 0, 0};
    tbl[2] = '{1'b1, 1'b1, 20, 1, 0, 0};
    tbl[3] = '{1'b1, 1'b0,  5, 2, 1, 0};
    tbl[4] = '{1'b0, 1'b1,  4, 2, 0, 0};
    tbl[5] = '{1'b0, 1'b1,  5, 1, 0, 1};
    tbl[6] = '{1'b1, 1'b0, 12, 2, 1, 0};
    tbl[7] = '{1'b1, 1'b0, 13, 4, 2, 0};
    tbl[8] = '{1'b0, 1'b1, 13, 2, 0, 2};
    tbl[9] = '{1'b0, 1'b1, 21, 0, 0, 2};

    Reset = 1'b1; reset2 = 1'b1;
    btn_up = 1'b0; btn_dn = 1'b0; fade_start = 1'b0; fade_dir = 1'b0; btn_up2 = 1'b0;
    repeat (3) tick();
    chk("rst_level", int'(level), 0);
    chk("rst_therm", int'(therm), 0);
    chk("rst_step_up", int'(step_up), 0);
    chk("rst_step_dn", int'(step_dn), 0);
    chk("rst_fade_active", int'(fade_active), 0);
    chk("rst_fade_done", int'(fade_done), 0);
    chk("rst2_level", int'(level2), 2);
    chk("rst2_therm", int'(therm2), 8'h03);
    Reset = 1'b0;
    n_up = 0; n_dn = 0; n_done = 0;

    // Single press: step lands exactly on edge k+6.
    btn_up = 1'b1;
    repeat (6) tick();
    chk("t1_before_latency", int'(level), 0);
    btn_up = 1'b0;
    tick();
    chk("t1_level", int'(level), 1);
    chk("t1_therm", int'(therm), 8'h01);
    chk("t1_step_up", int'(step_up), 1);
    tick();
    chk("t1_pulse_one_cycle", int'(step_up), 0);
    repeat (8) tick();
    chk("t1_level_after", int'(level), 1);
    chk("t1_up_count", n_up, 1);

    for (int i = 0; i < 10; i++) begin
      up0 = n_up; dn0 = n_dn;
      btn_up = tbl[i].up; btn_dn = tbl[i].dn;
      repeat (tbl[i].cyc) tick();
      btn_up = 1'b0; btn_dn = 1'b0;
      repeat (6) tick();
      chk($sformatf("vec%0d_level", i), int'(level), tbl[i].lvl);
      chk($sformatf("vec%0d_therm", i), int'(therm), (1 << tbl[i].lvl) - 1);
      chk($sformatf("vec%0d_nup", i), n_up - up0, tbl[i].nup);
      chk($sformatf("vec%0d_ndn", i), n_dn - dn0, tbl[i].ndn);
    end

    // Continuous hold from 0: repeats every 8 edges, saturating at 8.
    up0 = n_up;
    btn_up = 1'b1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (i == 15) chk("t3_level_k14", int'(level), 2);
      if (i == 63) begin
        chk("t3_level_k62", int'(level), 8);
        chk("t3_therm_k62", int'(therm), 8'hFF);
        chk("t3_step_up_k62", int'(step_up), 1);
      end
      if (i == 71) begin
        chk("t3_sat_no_pulse", int'(step_up), 0);
        chk("t3_sat_level", int'(level), 8);
      end
    end
    btn_up = 1'b0;
    repeat (6) tick();
    chk("t3_up_count", n_up - up0, 8);

    // Fade down from 8.
    dn0 = n_dn; done0 = n_done;
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    chk("t4_fade_active", int'(fade_active), 1);
    for (int m = 1; m <= 24; m++) begin
      tick();
      chk($sformatf("t4_level_j%0d", m), int'(level), 8 - m / 3);
      if (m == 3)  chk("t4_step_dn_j3", int'(step_dn), 1);
      if (m == 23) chk("t4_active_j23", int'(fade_active), 1);
    end
    chk("t4_fade_done", int'(fade_done), 1);
    chk("t4_active_drop", int'(fade_active), 0);
    chk("t4_therm", int'(therm), 0);
    tick();
    chk("t4_done_one_cycle", int'(fade_done), 0);
    chk("t4_dn_count", n_dn - dn0, 8);
    chk("t4_done_count", n_done - done0, 1);

    // Fade up aborted at level 5 by btn_dn, then the press is debounced.
    done0 = n_done;
    fade_dir = 1'b1; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    repeat (15) tick();
    chk("t5_level_j15", int'(level), 5);
    btn_dn = 1'b1;
    repeat (3) tick();
    chk("t5_abort_level", int'(level), 5);
    chk("t5_abort_active", int'(fade_active), 0);
    repeat (4) tick();
    chk("t5_level_j22", int'(level), 5);
    tick();
    chk("t5_level_j23", int'(level), 4);
    chk("t5_step_dn", int'(step_dn), 1);
    btn_dn = 1'b0;
    repeat (6) tick();
    chk("t5_level_final", int'(level), 4);
    chk("t5_no_fade_done", n_done - done0, 0);

    // Reset during HOLD on the INIT_LEVEL=2 instance.
    reset2 = 1'b0;
    tick();
    btn_up2 = 1'b1;
    repeat (7) tick();
    chk("t6_hold_level", int'(level2), 3);
    reset2 = 1'b1;
    tick();
    chk("t6_rst_level", int'(level2), 2);
    chk("t6_rst_therm", int'(therm2), 8'h03);
    chk("t6_rst_step_up", int'(step_up2), 0);
    chk("t6_rst_active", int'(fade_active2), 0);
    btn_up2 = 1'b0;
    tick();
    reset2 = 1'b0;
    repeat (12) tick();
    chk("t6_level_stays", int'(level2), 2);

    // Fade request already at its target level is ignored.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t6_reset_level0", int'(level), 0);
    done0 = n_done;
    fade_dir = 1'b0; fade_start = 1'b1;
    tick();
    fade_start = 1'b0;
    chk("t6_no_fade_entry", int'(fade_active), 0);
    repeat (6) tick();
    chk("t6_level_zero", int'(level), 0);
    chk("t6_no_fade_done", n_done - done0, 0);
    chk("t6_still_idle", int'(fade_active), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vol_step_ctrl.md
# vol_step_ctrl

Volume step controller for the pedal-board gain stage. It arbitrates between the raw front-panel up/down buttons and an automatic fade (swell) sequencer, and owns the 0..8 volume level. It emits one-cycle step pulses plus a thermometer gain mask and a level number for the hex display. It sits between the board switches and the audio gain/multiply path.

## Interface
- DEBOUNCE_CYCLES, 16'd50000: consecutive stable cycles required to accept a press (≥1).
- REPEAT_CYCLES, 24'd5000000: auto-repeat interval while a button stays held; 0 disables repeat.
- FADE_PERIOD, 24'd2500000: cycles between steps during a fade (≥1).
- INIT_LEVEL, 4'd0: level loaded on reset (0..8).

- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset; clock Clk
- btn_up  in  1  raw asynchronous volume-up button, active-high
- btn_dn  in  1  raw asynchronous volume-down button, active-high
- fade_start  in  1  one-cycle fade request
- fade_dir  in  1  fade direction, sampled with fade_start: 1 = up to 8, 0 = down to 0
- level  out  4  current volume level, 0..8
- therm  out  8  thermometer mask, (1<<level)-1 (8'h00..8'hFF)
- step_up  out  1  one-cycle pulse, level incremented this cycle
- step_dn  out  1  one-cycle pulse, level decremented this cycle
- fade_active  out  1  high while in FADE
- fade_done  out  1  one-cycle pulse, fade reached its end level

## Operation
- Buttons pass through a 2-FF synchronizer into s_up/s_dn. Raw buttons are never used directly.
- Press pattern is valid only when exactly one of s_up, s_dn is high. Both high counts as no press.
- States:
  - IDLE: a valid pattern moves to DEBOUNCE with cnt=0 and latches dir. Otherwise, fade_start moves to FADE with timer=0, unless the level is already at the fade target. In that case stay in IDLE with no fade_done. A button takes priority over fade_start in the same cycle.
  - DEBOUNCE: if the pattern equals the latched one, cnt++. On cnt==DEBOUNCE_CYCLES-1, apply a step and go to HOLD with rcnt=0. Any pattern change returns to IDLE with no step.
  - HOLD: stay until s_up=s_dn=0, then go to IDLE. If REPEAT_CYCLES≠0 and the latched pattern is still held, rcnt++. On rcnt==REPEAT_CYCLES-1, apply a step and clear rcnt. If the pattern switches to the other button, the latched pattern is no longer held and repeat stops; the FSM still waits for full release.
  - FADE: timer++. On timer==FADE_PERIOD-1, apply a step in fade_dir and clear the timer. When the step reaches 8 (up) or 0 (down), pulse fade_done on that same edge and go to IDLE. Any s_up or s_dn high aborts: go to IDLE with no step and no fade_done. fade_start during FADE is ignored.
- Applying a step:
  - level±1, saturating at 0 and 8.
  - step_up/step_dn pulse only when the level actually changes. A saturated step produces no pulse and no level change.
- fade_start arriving in DEBOUNCE or HOLD is dropped.
- therm and level are registered and always consistent (therm == (1<<level)-1).

## Timing
- Reset values: level=INIT_LEVEL, therm=(1<<INIT_LEVEL)-1, step_up=step_dn=fade_active=fade_done=0, state=IDLE, all counters 0, synchronizer flops 0.
- Reset mid-debounce, mid-hold or mid-fade aborts immediately with no step.
- Press latency: btn_up first sampled high at edge k and held gives level/therm/step_up updated after edge k+2+DEBOUNCE_CYCLES.
- Repeat: subsequent steps come every REPEAT_CYCLES edges while held.
- Fade: fade_start at edge j gives fade_active high after j. The first step is after edge j+FADE_PERIOD, then one step every FADE_PERIOD edges. fade_active drops on the same edge that fade_done pulses.
- All outputs are registered; there is no combinational input-to-output path.

## Structure
- vol_pkg holds: state enum {IDLE, DEBOUNCE, HOLD, FADE}, constant LEVEL_MAX=4'd8, and a function for the therm mask.
- One sub-module, sync_2ff, instantiated twice (for btn_up and btn_dn).
- FSM, counters and level register live in vol_step_ctrl.

## Test plan
Bench parameters: DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8, FADE_PERIOD=3, INIT_LEVEL=0.

1. Reset, then hold btn_up for 6 cycles from edge k → after edge k+6: level=1, therm=8'h01, one step_up pulse; release → IDLE, no further steps.
2. btn_up glitch of 3 cycles, then low → level stays 0, no step pulse. btn_up and btn_dn high together for 20 cycles → no step.
3. Hold btn_up continuously → steps at k+6, k+14, k+22, …; level saturates at 8, therm=8'hFF, no step_up pulse on attempts beyond 8.
4. At level 8, fade_start with fade_dir=0 at edge j → step_dn at j+3, j+6, …, j+24; level=0 and fade_done pulse at j+24; fade_active low afterward.
5. Mid-fade (level 5), assert btn_dn → fade aborted, no fade_done; the press is then debounced normally → level 4.
6. Assert Reset during HOLD at level 3 with INIT_LEVEL=2 → next cycle level=2, therm=8'h03, state IDLE; fade_start at level 0 with fade_dir=0 → no FADE entry, no fade_done.
